// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CPU definitions used by the coprocessor-0 block.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - exception codes written into Cause.ExcCode
//   - default PRId contents and default exception handler address
//   - mode_e: the CP0 operating mode, which is exactly the SR.EXL bit
//   - epc_target(): return address recorded when an exception is taken
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEFAULT_PRID       = 32'h0000_4C58;
  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

  // MODE_HANDLER corresponds to SR.EXL = 1.
  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    logic [31:0] t;
    t = bd ? (pc - 32'd4) : pc;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: signals between the memory stage of the pipeline and CP0.
//   master : pipeline side (drives M-stage info, mtc0/mfc0 access, irq lines)
//   slave  : CP0 side (returns rdata, int_req, epc, handler_pc)
// Handshake: there is no valid/ready pair. Every signal is a per-cycle level;
// CP0 samples all inputs on each posedge and its outputs are valid every cycle
// (int_req and rdata combinationally, epc and handler_pc from registers/constants).
interface cp0_if;
  logic [31:0] m_pc;
  logic [4:0]  m_ex;
  logic        m_bd;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] handler_pc;

  modport master (
    output m_pc, m_ex, m_bd, m_eret, hw_int, we, addr, wdata,
    input  rdata, int_req, epc, handler_pc
  );

  modport slave (
    input  m_pc, m_ex, m_bd, m_eret, hw_int, we, addr, wdata,
    output rdata, int_req, epc, handler_pc
  );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt responder at the end of the M stage.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : cp0_if.slave (M-stage info, mtc0/mfc0 access, hw_int in;
//                rdata, int_req, epc, handler_pc out)
//   mode       : debug view of the mode FSM (MODE_HANDLER == SR.EXL)
// Registers: SR(12) IM/EXL/IE, Cause(13) BD/IP/ExcCode, EPC(14), PRId(15).
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = DEFAULT_PRID,
  parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus,
  output mode_e mode
);

  logic [5:0]  sr_im;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic exl;
  logic irq;
  logic exc;
  logic int_req;
  logic sr_wr;
  logic epc_wr;

  assign exl     = (mode == MODE_HANDLER);
  assign irq     = (|(bus.hw_int & sr_im)) & sr_ie & ~exl;
  assign exc     = (bus.m_ex != 5'd0) & ~exl;
  assign int_req = irq | exc;

  // An mtc0 in the same cycle as a taken exception belongs to a squashed
  // instruction, so it must not land.
  assign sr_wr  = bus.we & ~int_req & (bus.addr == CP0_SR);
  assign epc_wr = bus.we & ~int_req & (bus.addr == CP0_EPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= MODE_NORMAL;
      sr_im     <= 6'd0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      // IP mirrors the lines every cycle, whatever the mode.
      cause_ip <= bus.hw_int;

      if (sr_wr) begin
        sr_im <= bus.wdata[15:10];
        sr_ie <= bus.wdata[0];
      end

      if (int_req) begin
        cause_bd  <= bus.m_bd;
        cause_exc <= irq ? EXC_INT : bus.m_ex;
        epc_q     <= epc_target(bus.m_pc, bus.m_bd);
      end else if (epc_wr) begin
        epc_q <= {bus.wdata[31:2], 2'b00};
      end

      case (mode)
        MODE_NORMAL: begin
          if (int_req)
            mode <= MODE_HANDLER;
          else if (sr_wr && bus.wdata[1])
            mode <= MODE_HANDLER;
        end
        MODE_HANDLER: begin
          // Clearing EXL here means a pending interrupt is seen next cycle.
          if (bus.m_eret)
            mode <= MODE_NORMAL;
          else if (sr_wr && !bus.wdata[1])
            mode <= MODE_NORMAL;
        end
        default: mode <= MODE_NORMAL;
      endcase
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      CP0_SR:    bus.rdata = {16'd0, sr_im, 8'd0, exl, sr_ie};
      CP0_CAUSE: bus.rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      CP0_EPC:   bus.rdata = epc_q;
      CP0_PRID:  bus.rdata = PRID_VAL;
      default:   bus.rdata = 32'd0;
    endcase
  end

  assign bus.int_req    = int_req;
  assign bus.epc        = epc_q;
  assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: self-checking bench for cp0. A driver issues one cycle of stimulus
// at a time and pushes the reference model's expected outputs into exp_q; a
// monitor on the falling edge pops and compares against the DUT.
module tb_cp0;
  import cp0_pkg::*;

  localparam logic [31:0] PRID = 32'h0000_4C58;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  // ---------------- clock / reset ----------------
  logic  clk;
  logic  reset;
  mode_e mode_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cp0_if bus ();

  cp0 #(.PRID_VAL(PRID), .HANDLER_PC(HPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .mode  (mode_dbg)
  );

  // ---------------- reference model ----------------
  // Architectural registers held as whole 32-bit words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  // {int_req, exl, rdata, epc}
  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [31:0] pc, input logic [4:0] ex,
                      input logic bd, input logic eret, input logic [5:0] hw,
                      input logic we, input logic [4:0] a, input logic [31:0] wd);
    logic exl, irq, exc, take;
    logic [4:0] code;
    @(posedge clk);
    #1;
    reset      = rst;
    bus.m_pc   = pc;
    bus.m_ex   = ex;
    bus.m_bd   = bd;
    bus.m_eret = eret;
    bus.hw_int = hw;
    bus.we     = we;
    bus.addr   = a;
    bus.wdata  = wd;

    exl  = m_sr[1];
    irq  = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !exl;
    exc  = (ex != 5'd0) && !exl;
    take = irq || exc;
    exp_q.push_back({take, exl, model_read(a), m_epc});

    // State seen after the coming edge.
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (take) begin
        code    = irq ? 5'd0 : ex;
        m_sr[1] = 1'b1;
        m_cause = ({31'd0, bd} << 31) | ({27'd0, code} << 2);
        m_epc   = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
      end else begin
        if (we && a == 5'd12) m_sr  = wd & 32'h0000_FC03;
        if (we && a == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
        if (eret && exl)      m_sr[1] = 1'b0;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      check("int_req",    {31'd0, bus.int_req}, {31'd0, e[65]});
      check("exl_mode",   {31'd0, (mode_dbg == MODE_HANDLER)}, {31'd0, e[64]});
      check("rdata",      bus.rdata, e[63:32]);
      check("epc",        bus.epc, e[31:0]);
      check("handler_pc", bus.handler_pc, HPC);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] ex_tab[5];
    logic [4:0] r_ex;
    logic       r_eret, r_we;
    ex_tab = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};

    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1;
    bus.m_pc = 0; bus.m_ex = 0; bus.m_bd = 0; bus.m_eret = 0;
    bus.hw_int = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(posedge clk);

    // Reset state reads.
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd13, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd14, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd15, 32'h0);
    // Interrupt: enable IM0+IE, raise line 0.
    step(0, 32'h0,    0, 0, 0, 6'b0,      1, 5'd12, 32'h0000_0401);
    step(0, 32'h3008, 0, 0, 0, 6'b000001, 0, 5'd13, 32'h0);
    step(0, 32'h300C, 0, 0, 0, 6'b000001, 0, 5'd12, 32'h0);
    step(0, 32'h300C, 0, 0, 0, 6'b000001, 0, 5'd13, 32'h0);
    step(0, 32'h300C, 0, 0, 0, 6'b000001, 0, 5'd14, 32'h0);
    // eret with the line still high: retaken one cycle later.
    step(0, 32'h4190, 0, 0, 1, 6'b000001, 0, 5'd12, 32'h0);
    step(0, 32'h3008, 0, 0, 0, 6'b000001, 0, 5'd12, 32'h0);
    // mtc0 SR in HANDLER clears EXL.
    step(0, 32'h4184, 0, 0, 0, 6'b0, 1, 5'd12, 32'h0000_0401);
    // Overflow in a delay slot.
    step(0, 32'h3014, 5'd12, 1, 0, 6'b0, 0, 5'd13, 32'h0);
    step(0, 32'h4180, 0, 0, 0, 6'b0, 0, 5'd13, 32'h0);
    step(0, 32'h4180, 0, 0, 0, 6'b0, 0, 5'd14, 32'h0);
    step(0, 32'h4184, 0, 0, 1, 6'b0, 0, 5'd12, 32'h0);
    // Exception and mtc0 EPC in the same cycle: write dropped.
    step(0, 32'h3020, 5'd4, 0, 0, 6'b0, 1, 5'd14, 32'h0000_5000);
    step(0, 32'h4180, 0, 0, 0, 6'b0, 0, 5'd14, 32'h0);
    step(0, 32'h4184, 0, 0, 1, 6'b0, 0, 5'd13, 32'h0);
    // EPC low bits forced to zero; PRId read-only.
    step(0, 32'h3024, 0, 0, 0, 6'b0, 1, 5'd14, 32'h0000_3003);
    step(0, 32'h3028, 0, 0, 0, 6'b0, 0, 5'd14, 32'h0);
    step(0, 32'h302C, 0, 0, 0, 6'b0, 1, 5'd15, 32'hFFFF_FFFF);
    step(0, 32'h3030, 0, 0, 0, 6'b0, 0, 5'd15, 32'h0);
    // Reset while in HANDLER, and reset on an int_req cycle.
    step(0, 32'h3030, 5'd5, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(1, 32'h4180, 0, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd13, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd14, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd15, 32'h0);
    step(0, 32'h3040, 5'd10, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(1, 32'h3044, 5'd10, 0, 0, 6'b0, 0, 5'd12, 32'h0);
    step(0, 32'h0, 0, 0, 0, 6'b0, 0, 5'd12, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      r_ex   = ($urandom_range(0, 5) == 0) ? ex_tab[$urandom_range(1, 4)] : 5'd0;
      r_eret = ($urandom_range(0, 7) == 0);
      r_we   = !r_eret && ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 59) == 0),
           $urandom(),
           r_ex,
           1'($urandom_range(0, 1)),
           r_eret,
           ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'd0,
           r_we,
           5'($urandom_range(10, 17)),
           ($urandom_range(0, 1) == 0) ? $urandom() : (32'($urandom_range(0, 63)) << 10) | 32'($urandom_range(0, 3)));
    end

    // Drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt responder at the memory-stage end of the pipeline. It consumes the exception code, branch-delay flag, PC and `eret` flag carried out of the E→M pipeline register, plus `mtc0`/`mfc0` accesses and six external hardware interrupt lines. It decides each cycle whether to take an exception or interrupt (`int_req`) and maintains SR, Cause, EPC and PRId. It supplies EPC as the `eret` return target.

## Interface
Parameters:
- `PRID_VAL`, default 32'h0000_4C58: read-only PRId contents.
- `HANDLER_PC`, default 32'h0000_4180: exported as `handler_pc` for fetch redirection.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; evaluated on posedge `clk`.
- `m_pc`  in  32  PC of the instruction in M.
- `m_ex`  in  5  exception code of the instruction in M; 0 = none.
- `m_bd`  in  1  instruction in M is in a branch-delay slot.
- `m_eret`  in  1  instruction in M is `eret`.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `we`  in  1  `mtc0` write enable.
- `addr`  in  5  CP0 register number for read and write.
- `wdata`  in  32  `mtc0` data.
- `rdata`  out  32  `mfc0` read data, combinational.
- `int_req`  out  1  take exception/interrupt this cycle, combinational.
- `epc`  out  32  current EPC register.
- `handler_pc`  out  32  constant `HANDLER_PC`.

## Operation
Registers:
- SR(12): bits [15:10] IM, [1] EXL, [0] IE. All other bits read 0. Writable via `mtc0`.
- Cause(13): [31] BD, [15:10] IP, [6:2] ExcCode. All other bits read 0. Read-only to software.
- EPC(14): 32 bits, writable via `mtc0`. Bits [1:0] are forced to 0 on every write.
- PRId(15): constant `PRID_VAL`. Writes are ignored.
- Any other `addr` reads 0; writes to it are ignored.

Request logic:
- `irq = |(hw_int & IM) & IE & !EXL`
- `exc = (m_ex != 0) & !EXL`
- `int_req = irq | exc`

Mode FSM, encoded by EXL:
- NORMAL (EXL=0):
  - When `int_req`: go to HANDLER.
  - Otherwise: stay in NORMAL.
- HANDLER (EXL=1):
  - When `m_eret`: go to NORMAL.
  - Otherwise: stay in HANDLER.

On an `int_req` edge, in addition to setting EXL:
- ExcCode ← 0 if `irq`, else `m_ex`. Interrupt has priority over an exception in the same cycle.
- BD ← `m_bd`.
- EPC ← (`m_bd` ? `m_pc` − 4 : `m_pc`) with bits [1:0] zeroed. Arithmetic is 32-bit modulo.

IP is updated every cycle from `hw_int`, independent of EXL.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0. Consequently `int_req` = 0, `epc` = 0, and `rdata` = 0 except for `addr` 15.
- `int_req` and `rdata` are combinational from the current inputs and the registered state. All register effects become visible on the edge after the condition.
- `mfc0` of Cause returns IP as latched on the previous edge.

Simultaneous events:
- `int_req` and `we` in the same cycle: the `mtc0` is discarded, because the instruction is being squashed.
- `m_eret` while EXL=0: no state change.
- `m_eret` while EXL=1 with a pending `hw_int`: EXL clears at the edge. The interrupt is taken no earlier than the next cycle.
- `mtc0` to SR while EXL=1: the written value, including EXL, takes effect at the edge. If EXL becomes 0 and an enabled interrupt is pending, `int_req` rises in the following cycle.
- Exceptions with EXL=1 are ignored; Cause and EPC are held.
- Reset in any state, including the same cycle as `int_req`: reset wins and all registers take their reset values.

## Structure
- Shared CPU package holds:
  - register-number constants (`CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15);
  - the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12);
  - the default handler address.
- Single module with no sub-modules; the block is roughly 130–180 lines.

## Test plan
- Reset, then read `addr` 12, 13, 14, 15 → 0, 0, 0, 32'h0000_4C58. `int_req` = 0.
- `mtc0` SR = 32'h0000_0401, then `hw_int` = 6'b000001 with `m_pc` = 32'h3008 and `m_bd` = 0 → `int_req` = 1 the same cycle. Next cycle: EXL = 1, ExcCode = 0, EPC = 32'h3008, and `int_req` = 0 while the line stays high.
- EXL = 0, `m_ex` = 12 (Ov), `m_bd` = 1, `m_pc` = 32'h3014 → `int_req` = 1. Next cycle: Cause[31] = 1, ExcCode = 12, EPC = 32'h3010.
- In HANDLER, `m_eret` = 1 with `hw_int` enabled and held high → `int_req` = 0 that cycle. The edge clears EXL, and `int_req` = 1 on the following cycle.
- `int_req` and `mtc0` EPC = 32'h5000 in the same cycle with `m_pc` = 32'h3020 → EPC = 32'h3020 and the write is dropped.
- `mtc0` EPC = 32'h3003 → EPC reads 32'h3000. `mtc0` to PRId → unchanged. Assert `reset` in HANDLER → all registers return to reset values.
